// File: rtl/dbg_pkg.sv
// Shared constants for the debug command sequencer: command codes, FSM states, reply bytes.
package dbg_pkg;

  localparam logic [31:0] CMD_RST1 = 32'h3154_5352;
  localparam logic [31:0] CMD_RST0 = 32'h3054_5352;
  localparam logic [31:0] CMD_IMEN = 32'h6E45_4D49;
  localparam logic [31:0] CMD_CCLK = 32'h6B6C_6363;
  localparam logic [31:0] CMD_CLK0 = 32'h3030_3030;

  localparam logic [7:0] REPLY_ACK = 8'h4B;
  localparam logic [7:0] REPLY_ERR = 8'h45;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_ADDR,
    ST_DATA,
    ST_RISE,
    ST_FALL
  } state_t;

  function automatic logic is_run_cmd(input logic [31:0] w);
    return (w == CMD_RST1) || (w == CMD_RST0) || (w == CMD_IMEN) ||
           (w == CMD_CCLK) || (w == CMD_CLK0);
  endfunction

endpackage

// File: rtl/dbg_packet_assembler.sv
// Collects four rx bytes (little-endian) into one registered packet word; a stalled
// partial packet is discarded after TIMEOUT_CYC idle cycles and flagged on pkt_drop.
module dbg_packet_assembler
  import dbg_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] pkt_word,
  output logic        pkt_valid,
  output logic        pkt_drop
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       idx_q;
  logic [23:0]      shift_q;
  logic [CNT_W-1:0] idle_q;
  logic [31:0]      word_q;
  logic             valid_q;
  logic             drop_q;
  logic             expire;

  // An arriving byte always beats an expiring counter.
  assign expire = (idx_q != 2'd0) && !rx_valid &&
                  (idle_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
      idle_q  <= '0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      if (rx_valid) begin
        idle_q <= '0;
        if (idx_q == 2'd3) begin
          word_q  <= {rx_data, shift_q};
          valid_q <= 1'b1;
          idx_q   <= 2'd0;
        end else begin
          shift_q <= {rx_data, shift_q[23:8]};
          idx_q   <= idx_q + 2'd1;
        end
      end else if (expire) begin
        idx_q  <= 2'd0;
        idle_q <= '0;
        drop_q <= 1'b1;
      end else if (idx_q != 2'd0) begin
        idle_q <= idle_q + CNT_W'(1);
      end
    end
  end

  assign pkt_word  = word_q;
  assign pkt_valid = valid_q;
  assign pkt_drop  = drop_q;

endmodule

// File: rtl/dbg_cmd_sequencer.sv
// Debug command sequencer: decodes host packets into CPU reset/step and imem writes.
// Define DBG_ACK_EN to add a tx reply port ('K' accepted, 'E' error) with a 1-deep buffer.
module dbg_cmd_sequencer
  import dbg_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 2000000
) (
`ifdef DBG_ACK_EN
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
`endif
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              CPU_clk,
  output logic              CPU_reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              imem_we,
  output logic              prog_mode,
  output logic              cmd_err,
  output logic [7:0]        err_cnt
);

  logic [31:0] pkt_word;
  logic        pkt_valid;
  logic        pkt_drop;

  dbg_packet_assembler #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_asm (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .pkt_word (pkt_word),
    .pkt_valid(pkt_valid),
    .pkt_drop (pkt_drop)
  );

  state_t            state_q;
  logic              cpu_clk_q;
  logic              cpu_reset_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              imem_we_q;
  logic              prog_mode_q;
  logic              cmd_err_q;
  logic [7:0]        err_cnt_q;
  logic [7:0]        err_cnt_d;
  logic              pkt_err;

  always_comb begin
    pkt_err = 1'b0;
    case (state_q)
      ST_RUN:  pkt_err = !is_run_cmd(pkt_word);
      ST_RISE: pkt_err = (pkt_word != CMD_CCLK);
      ST_FALL: pkt_err = (pkt_word != CMD_CLK0);
      default: pkt_err = 1'b0;
    endcase
  end

  assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cpu_clk_q    <= 1'b0;
      cpu_reset_q  <= 1'b1;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      imem_we_q    <= 1'b0;
      prog_mode_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      imem_we_q <= 1'b0;
      cmd_err_q <= 1'b0;
      if (pkt_drop || (pkt_valid && pkt_err)) begin
        cmd_err_q <= 1'b1;
        err_cnt_q <= err_cnt_d;
      end
      if (pkt_valid) begin
        case (state_q)
          ST_RUN: begin
            if (pkt_word == CMD_RST1) cpu_reset_q <= 1'b1;
            if (pkt_word == CMD_RST0) cpu_reset_q <= 1'b0;
            if (pkt_word == CMD_CCLK) cpu_clk_q <= 1'b1;
            if (pkt_word == CMD_CLK0) cpu_clk_q <= 1'b0;
            if (pkt_word == CMD_IMEN) begin
              state_q     <= ST_ADDR;
              prog_mode_q <= 1'b1;
              cpu_clk_q   <= 1'b0;
            end
          end
          ST_ADDR: begin
            if (pkt_word == CMD_IMEN) begin
              state_q     <= ST_RUN;
              prog_mode_q <= 1'b0;
            end else begin
              imem_addr_q <= pkt_word[ADDR_W-1:0];
              state_q     <= ST_DATA;
            end
          end
          ST_DATA: begin
            imem_wdata_q <= pkt_word;
            state_q      <= ST_RISE;
          end
          ST_RISE: begin
            if (pkt_word == CMD_CCLK) begin
              cpu_clk_q <= 1'b1;
              imem_we_q <= 1'b1;
              state_q   <= ST_FALL;
            end else begin
              state_q <= ST_ADDR;
            end
          end
          ST_FALL: begin
            // A wrong word here still lowers the clock so the CPU is never left high.
            cpu_clk_q <= 1'b0;
            state_q   <= ST_ADDR;
          end
          default: state_q <= ST_RUN;
        endcase
      end
    end
  end

  assign CPU_clk    = cpu_clk_q;
  assign CPU_reset  = cpu_reset_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign imem_we    = imem_we_q;
  assign prog_mode  = prog_mode_q;
  assign cmd_err    = cmd_err_q;
  assign err_cnt    = err_cnt_q;

`ifdef DBG_ACK_EN
  logic [7:0] tx_data_q;
  logic       tx_valid_q;

  // A fresh reply replaces any pending one, even in the cycle it is being taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
    end else if (pkt_drop || pkt_valid) begin
      tx_data_q  <= (pkt_drop || pkt_err) ? REPLY_ERR : REPLY_ACK;
      tx_valid_q <= 1'b1;
    end else if (tx_ready) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
`endif

endmodule
